// File: rtl/simon_sequence_player.sv
// Simon sequence player.
// Each accepted round start appends one colour (taken from the LFSR) to the
// sequence memory, then replays the whole sequence on a one-hot LED bus
// with fixed ON/OFF timing. A combinational read port lets the input
// checker compare presses against the stored sequence at any time.
//
// Handshake: start_round is a single-cycle request with no ready. It is
// accepted only in IDLE when clear is low; in any other state it is
// dropped, not queued. done is a single-cycle completion strobe.
module simon_sequence_player #(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       rand_color,
    input  logic             start_round,
    input  logic             clear,
    output logic [3:0]       led_onehot,
    output logic             playing,
    output logic             done,
    output logic [LEN_W-1:0] seq_len,
    output logic             seq_full,
    input  logic [LEN_W-1:0] rd_idx,
    output logic [1:0]       rd_color
);

    // Memory address width; the memory is rounded up to a power of two so
    // that an address slice indexes it without width adaptation.
    localparam int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [LEN_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mem [DEPTH];

    logic             append;
    logic             on_last;
    logic             off_last;
    logic             last_entry;

    // A colour is written only for an accepted, non-full round start.
    assign append     = (state == S_IDLE) && start_round && !clear && !seq_full;
    assign on_last    = (cnt == CNT_W'(ON_CYCLES - 1));
    assign off_last   = (cnt == CNT_W'(OFF_CYCLES - 1));
    assign last_entry = (idx == seq_len - LEN_W'(1));

    // Playback sequencer: state, entry index, phase counter and length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            seq_len  <= '0;
            seq_full <= 1'b0;
        end else if (clear) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            seq_len  <= '0;
            seq_full <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_round) begin
                        if (!seq_full) begin
                            seq_len  <= seq_len + LEN_W'(1);
                            seq_full <= (seq_len == LEN_W'(MAX_LEN - 1));
                        end
                        idx   <= '0;
                        cnt   <= '0;
                        state <= S_ON;
                    end
                end
                S_ON: begin
                    if (on_last) begin
                        cnt   <= '0;
                        state <= S_OFF;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (off_last) begin
                        cnt <= '0;
                        if (last_entry) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            state <= S_ON;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sequence storage; contents survive reset and clear, only seq_len moves.
    always_ff @(posedge clk) begin
        if (append) begin
            mem[seq_len[ADDR_W-1:0]] <= rand_color;
        end
    end

    // LED decode from registered state and index; dark outside ON.
    always_comb begin
        led_onehot = 4'b0000;
        if (state == S_ON) begin
            led_onehot[mem[idx[ADDR_W-1:0]]] = 1'b1;
        end
    end

    assign playing  = (state == S_ON) || (state == S_OFF);
    assign done     = (state == S_DONE);
    assign rd_color = (rd_idx < seq_len) ? mem[rd_idx[ADDR_W-1:0]] : 2'b00;

endmodule

// File: doc/simon_sequence_player.md
Name: simon_sequence_player

Overview:
- Downstream consumer of the LFSR colour source in the Simon game datapath.
- On each round start it appends one random 2-bit colour, sampled from lfsr rand_out[1:0], to a sequence memory.
- It then replays the whole sequence on a one-hot 4-LED bus with fixed on/off timing.
- It also exposes a read port so the player-input checker can compare presses against the stored sequence.

Parameters:
- MAX_LEN, 32, maximum sequence length in entries; LEN_W = $clog2(MAX_LEN+1).
- ON_CYCLES, 25000000, cycles each LED stays lit; must be >= 1.
- OFF_CYCLES, 12500000, dark gap after each LED; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rand_color  in  2  random colour from lfsr rand_out[1:0].
- start_round  in  1  1-cycle pulse: append a colour and play; honoured only in IDLE.
- clear  in  1  synchronous game restart.
- led_onehot  out  4  lit LED; colour 0->0001, 1->0010, 2->0100, 3->1000; 0000 when dark.
- playing  out  1  high from the first ON cycle through the last OFF cycle.
- done  out  1  1-cycle pulse after playback completes.
- seq_len  out  LEN_W  number of stored entries.
- seq_full  out  1  seq_len == MAX_LEN.
- rd_idx  in  LEN_W  checker read address.
- rd_color  out  2  mem[rd_idx], combinational; 2'b00 when rd_idx >= seq_len.

Behaviour:
- Reset (rst_n low, async): state IDLE, seq_len=0, idx=0, cnt=0, led_onehot=0000, playing=0, done=0, seq_full=0. Memory contents are not reset.
- States: IDLE, ON, OFF, DONE. idx is LEN_W wide; cnt is wide enough for max(ON_CYCLES, OFF_CYCLES).
- IDLE, start_round=1 at edge k:
  - If not full: mem[seq_len] <= rand_color (the value present at edge k); seq_len <= seq_len+1.
  - If full: no write, seq_len unchanged; the existing sequence is replayed.
  - idx <= 0, cnt <= 0, state <= ON.
- ON: led_onehot = onehot(mem[idx]) and playing=1. After exactly ON_CYCLES cycles in ON, go to OFF with cnt cleared.
- OFF: led_onehot=0000, playing=1. After exactly OFF_CYCLES cycles:
  - If idx == seq_len-1, go to DONE.
  - Otherwise idx <= idx+1 and go to ON.
- DONE: done=1 and playing=0 for exactly one cycle, then IDLE.
- Outputs are decoded from registered state, idx and cnt. There is no glitch requirement beyond a single clock domain.
- Latency: the first LED is lit in the cycle immediately after edge k. Playback for N entries lasts N*(ON_CYCLES+OFF_CYCLES) cycles; done follows in the next cycle.
- start_round outside IDLE is ignored; no queuing.
- clear (sync) has priority over everything, including a simultaneous start_round: state IDLE, seq_len=0, idx=0, cnt=0, outputs dark, done=0.
- Async reset mid-playback aborts immediately to the reset values. Playback does not resume.
- seq_full is registered consistently with seq_len and updates the same edge seq_len does.
- rand_color is sampled only on an accepted, non-full start_round; the LFSR free-runs otherwise.
- rd_color is valid in every state; the checker may read during playback.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2, MAX_LEN=4):
- Reset then idle -> led_onehot=0000, seq_len=0, playing=0, done=0, rd_color=00 for all rd_idx.
- rand_color=2, start_round pulse at edge k -> led=0100 for cycles k+1..k+3, 0000 for k+4..k+5, done=1 at k+6 only; seq_len=1, rd_color(idx0)=2.
- Round 2 with rand_color=1 -> LED sequence 0100×3, 0000×2, 0010×3, 0000×2, then done; total 10 playing cycles; seq_len=2.
- Five rounds with colours 0,1,2,3,0 -> after round 4, seq_full=1; round 5 appends nothing, seq_len stays 4, and replay shows 0001, 0010, 0100, 1000.
- start_round pulsed during ON and OFF -> ignored; seq_len unchanged and timing unaffected. clear during playback -> next cycle IDLE, seq_len=0, led=0000, no done pulse.
- Assert rst_n low mid-OFF, between clock edges -> outputs zero immediately, before the next edge; after release, seq_len=0 and a new start_round plays a length-1 sequence.
